// File: rtl/signed_2s_comp_add.sv
// Registered signed adder built from 4-bit carry-lookahead groups chained by ripple.
// Reports raw overflow/carry, optionally saturates, and holds its result when idle.
module signed_2s_comp_add #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             sat_en,
  output logic [WIDTH-1:0] s_add,
  output logic             out_valid,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] raw;
  logic             c_top;
  logic             c_msb;
  logic             ovf_next;
  logic [WIDTH-1:0] sum_next;

  assign g = num1 & num2;
  assign p = num1 ^ num2;

  // Each group keeps its carries local so the inter-group chain is a set of
  // distinct nets rather than feedback within one vector.
  generate
    for (genvar gi = 0; gi < NG; gi++) begin : grp
      localparam int B = gi * GROUP;
      logic cin;
      logic c1;
      logic c2;
      logic c3;
      logic gg;
      logic pp;
      logic cout;

      if (gi == 0) begin : g_first
        assign cin = 1'b0;
      end else begin : g_chain
        assign cin = grp[gi-1].cout;
      end

      assign c1 = g[B] | (p[B] & cin);
      assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cin);
      assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                | (p[B+2] & p[B+1] & p[B] & cin);
      assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign pp = p[B+3] & p[B+2] & p[B+1] & p[B];
      assign cout = gg | (pp & cin);

      assign raw[B]   = p[B]   ^ cin;
      assign raw[B+1] = p[B+1] ^ c1;
      assign raw[B+2] = p[B+2] ^ c2;
      assign raw[B+3] = p[B+3] ^ c3;
    end
  endgenerate

  assign c_top    = grp[NG-1].cout;
  assign c_msb    = grp[NG-1].c3;
  assign ovf_next = c_top ^ c_msb;

  // On overflow both operands share a sign, so num1's sign picks the rail.
  always_comb begin
    sum_next = raw;
    if (sat_en && ovf_next) begin
      sum_next = num1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_add     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (in_valid) begin
      s_add     <= sum_next;
      out_valid <= 1'b1;
      overflow  <= ovf_next;
      carry     <= c_top;
      zero      <= (sum_next == '0);
      negative  <= sum_next[WIDTH-1];
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signed_2s_comp_add.sv
// Directed-vector bench for signed_2s_comp_add with hand-computed expectations.
module tb_signed_2s_comp_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        sat_en;
  logic [31:0] s_add;
  logic        out_valid;
  logic        overflow;
  logic        carry;
  logic        zero;
  logic        negative;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  signed_2s_comp_add #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .num1      (num1),
    .num2      (num2),
    .sat_en    (sat_en),
    .s_add     (s_add),
    .out_valid (out_valid),
    .overflow  (overflow),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge capture, sample 1 ns later.
  task automatic step(input logic r, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic s);
    @(negedge clk);
    rst = r; in_valid = v; num1 = a; num2 = b; sat_en = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] sum,
                            input logic o, input logic c, input logic z, input logic n);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".s_add"},     s_add, sum);
    chk({tag, ".overflow"},  {31'b0, overflow}, {31'b0, o});
    chk({tag, ".carry"},     {31'b0, carry}, {31'b0, c});
    chk({tag, ".zero"},      {31'b0, zero}, {31'b0, z});
    chk({tag, ".negative"},  {31'b0, negative}, {31'b0, n});
    $display("step %-10s valid=%b s_add=%h ovf=%b carry=%b zero=%b neg=%b",
             tag, out_valid, s_add, overflow, carry, zero, negative);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; num1 = '0; num2 = '0; sat_en = 1'b0;

    // Reset wins over a simultaneous valid
    step(1, 1, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    expect_out("reset", 0, 32'h0, 0, 0, 0, 0);

    step(0, 1, 32'd1010, 32'd1000, 0);
    expect_out("pos", 1, 32'h0000_07DA, 0, 0, 0, 0);

    step(0, 1, 32'hEFFF_DAD0, 32'hED9C_87BF, 0);
    expect_out("negneg", 1, 32'hDD9C_628F, 0, 1, 0, 1);

    step(0, 1, 32'd263, 32'hEFFD_8C7D, 0);
    expect_out("mixed", 1, 32'hEFFD_8D84, 0, 0, 0, 1);

    step(0, 1, 32'd5, 32'hFFFF_FFFB, 0);
    expect_out("cancel", 1, 32'h0, 0, 1, 1, 0);

    step(0, 1, 32'h7FFF_FFFF, 32'h1, 0);
    expect_out("wrap", 1, 32'h8000_0000, 1, 0, 0, 1);

    step(0, 1, 32'h7FFF_FFFF, 32'h1, 1);
    expect_out("satpos", 1, 32'h7FFF_FFFF, 1, 0, 0, 0);

    step(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    expect_out("satneg", 1, 32'h8000_0000, 1, 1, 0, 1);

    // Saturation enabled but no overflow leaves the raw sum alone
    step(0, 1, 32'd1, 32'd2, 1);
    expect_out("satnoovf", 1, 32'h3, 0, 0, 0, 0);

    // Full-length carry propagation through every group
    step(0, 1, 32'hFFFF_FFFF, 32'h1, 0);
    expect_out("ripple", 1, 32'h0, 0, 1, 1, 0);

    step(0, 1, 32'h0F0F_0F0F, 32'h0101_0101, 0);
    expect_out("nibbles", 1, 32'h1010_1010, 0, 0, 0, 0);

    // Back-to-back stream
    step(0, 1, 32'd1, 32'd2, 0);
    expect_out("b2b0", 1, 32'h3, 0, 0, 0, 0);
    step(0, 1, 32'd100, 32'hFFFF_FFFF, 0);
    expect_out("b2b1", 1, 32'd99, 0, 1, 0, 0);
    step(0, 1, 32'h4000_0000, 32'h4000_0000, 0);
    expect_out("b2b2", 1, 32'h8000_0000, 1, 0, 0, 1);

    // Idle cycles hold result and flags
    step(0, 0, 32'd7, 32'd9, 1);
    expect_out("hold0", 0, 32'h8000_0000, 1, 0, 0, 1);
    step(0, 0, 32'h0, 32'h0, 0);
    expect_out("hold1", 0, 32'h8000_0000, 1, 0, 0, 1);

    // Reset mid-stream discards the in-flight operand pair
    step(0, 1, 32'd5, 32'hFFFF_FFFB, 0);
    expect_out("prerst", 1, 32'h0, 0, 1, 1, 0);
    step(1, 1, 32'd11, 32'd22, 0);
    expect_out("midrst", 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 32'd11, 32'd22, 0);
    expect_out("postrst", 0, 32'h0, 0, 0, 0, 0);
    step(0, 1, 32'd11, 32'd22, 0);
    expect_out("first", 1, 32'd33, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/signed_2s_comp_add.md
Name: signed_2s_comp_add

Overview:
- Registered 32-bit signed two's-complement adder with status flags and optional saturation.
- Used as the integer add stage of the datapath.
- Operands are sampled on a valid strobe. The sum and flags appear one clock later.
- The adder is built structurally from 4-bit carry-lookahead groups in a ripple-of-groups chain. The behavioural "+" operator is not used.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of 4.
- GROUP, 4, carry-lookahead group size in bits; fixed at 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies num1/num2/sat_en for capture on this edge.
- num1  input  WIDTH  signed addend A (two's complement).
- num2  input  WIDTH  signed addend B (two's complement).
- sat_en  input  1  1 = saturate on signed overflow; 0 = wrap.
- s_add  output  WIDTH  registered signed sum.
- out_valid  output  1  s_add and flags are valid this cycle.
- overflow  output  1  signed overflow of the raw (unsaturated) sum.
- carry  output  1  unsigned carry-out of bit WIDTH-1.
- zero  output  1  s_add == 0 (after saturation).
- negative  output  1  s_add[WIDTH-1] (after saturation).

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- While rst=1 at a clk edge, all outputs are cleared: s_add=0, out_valid=0, overflow=0, carry=0, zero=0, negative=0. rst has priority over in_valid on the same edge.
- Combinational core:
  - Per bit: g=a&b, p=a^b.
  - Per 4-bit group: compute group G/P and internal carries by lookahead equations.
  - Group carries chain from c0=0 through WIDTH/4 groups.
  - raw[i] = p[i] ^ c[i]; carry = c[WIDTH]; overflow = c[WIDTH] ^ c[WIDTH-1].
  - Equivalently, overflow = 1 when both operands share a sign and the raw sign differs.
- Saturation:
  - Applies only if sat_en=1 and overflow=1.
  - Positive overflow (both operands non-negative) gives 0x7FFFFFFF.
  - Negative overflow (both operands negative) gives 0x80000000.
  - Otherwise s_add=raw.
- carry and overflow always report the raw add, regardless of sat_en.
- zero and negative are derived from the final (possibly saturated) s_add.
- Latency is 1 cycle. On an edge with in_valid=1, the result and all flags are registered and out_valid=1 the next cycle.
- On an edge with in_valid=0: out_valid goes 0, and s_add plus all flags hold their previous values.
- Back-to-back in_valid=1 gives one result per cycle. There is no backpressure and no stall.
- Any operand pair is legal; there are no illegal input combinations.
- Reset mid-stream discards the in-flight result. The first post-reset result appears one cycle after the first in_valid following reset deassertion.

Test Plan:
- Reset: assert rst with in_valid=1 and arbitrary operands -> next cycle all outputs 0, out_valid=0.
- Positive add: num1=1010, num2=1000, sat_en=0 -> s_add=2010 (0x000007DA), overflow=0, carry=0, zero=0, negative=0.
- Negative + negative: num1=-0x10002530, num2=-0x12637841 -> s_add=0xDD9C628F, carry=1, overflow=0, negative=1.
- Mixed signs: num1=263, num2=-0x10027383 -> s_add=0xEFFD8D84, negative=1, overflow=0. Also 5 + (-5) -> s_add=0, zero=1, carry=1.
- Overflow wrap vs saturate:
  - 0x7FFFFFFF+1, sat_en=0 -> 0x80000000, overflow=1.
  - 0x7FFFFFFF+1, sat_en=1 -> 0x7FFFFFFF, overflow=1.
  - 0x80000000+0xFFFFFFFF, sat_en=1 -> 0x80000000, overflow=1, carry=1.
- Valid/hold: three back-to-back valid inputs give three consecutive out_valid=1 results in order. Dropping in_valid gives out_valid=0 with s_add held.
